// File: rtl/octal_down_timer_if.sv
// Handshake/bus bundle for octal_down_timer.
// The controller side (master) drives start/en/load_val and reads the count
// and status. The timer side (slave) does the reverse.
// With OCTAL_TIMER_PERIODIC_EN defined, the bundle also carries a periodic
// request line.
interface octal_down_timer_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic                  en;
  logic [3*DIGITS-1:0]   load_val;
`ifdef OCTAL_TIMER_PERIODIC_EN
  logic                  periodic;
`endif
  logic [3*DIGITS-1:0]   cntr;
  logic [DIGITS-1:0]     bw;
  logic                  busy;
  logic                  done;

`ifdef OCTAL_TIMER_PERIODIC_EN
  modport master (
    output start, en, load_val, periodic,
    input  cntr, bw, busy, done
  );
  modport slave (
    input  start, en, load_val, periodic,
    output cntr, bw, busy, done
  );
`else
  modport master (
    output start, en, load_val,
    input  cntr, bw, busy, done
  );
  modport slave (
    input  start, en, load_val,
    output cntr, bw, busy, done
  );
`endif
endinterface

// File: rtl/octal_down_timer.sv
// octal_down_timer: multi-digit octal down-counter used as a period or
// timeout generator. It loads an octal value on start and decrements once per
// enabled cycle. Each digit emits a one-cycle borrow pulse when it wraps from
// 0 to 7. A one-cycle done pulse fires when the count reaches zero.
//
// Optional feature macro: OCTAL_TIMER_PERIODIC_EN
//   Adds the periodic input and a reload register. When periodic is high in
//   DONE, the timer reloads the captured start value and runs again instead of
//   going back to IDLE.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; cntr holds its last value, bw = 0
// RUN     | counting down on each en=1 cycle; busy = 1
// DONE    | one-cycle terminal pulse; done = 1, cntr = 0
module octal_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  octal_down_timer_if.slave   bus
);

  localparam int W = 3 * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("octal_down_timer: DIGITS must be within 1..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      cnt_q, cnt_d;
  logic [DIGITS-1:0] bw_q, bw_d;

  // Borrow-chain decrement of the current count, with per-digit wrap flags.
  logic [W-1:0]      dec_cnt;
  logic [DIGITS-1:0] dec_bw;

  logic              cnt_is_zero;
  logic              cnt_is_one;

`ifdef OCTAL_TIMER_PERIODIC_EN
  logic [W-1:0]      reload_q, reload_d;
`endif

  assign cnt_is_zero = (cnt_q == '0);
  assign cnt_is_one  = (cnt_q == W'(1));

  // Ripple decrement: a digit steps only when every lower digit was 0.
  always_comb begin
    logic lower_zero;
    lower_zero = 1'b1;
    dec_cnt    = cnt_q;
    dec_bw     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (lower_zero) begin
        dec_cnt[3*i +: 3] = cnt_q[3*i +: 3] - 3'd1;
        dec_bw[i]         = (cnt_q[3*i +: 3] == 3'd0);
      end
      lower_zero = lower_zero & (cnt_q[3*i +: 3] == 3'd0);
    end
  end

  // State, count, borrow and reload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bw_q     <= '0;
`ifdef OCTAL_TIMER_PERIODIC_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
`ifdef OCTAL_TIMER_PERIODIC_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bw_d     = '0;
`ifdef OCTAL_TIMER_PERIODIC_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d    = bus.load_val;
`ifdef OCTAL_TIMER_PERIODIC_EN
          reload_d = bus.load_val;
`endif
          if (bus.load_val == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.en) begin
          if (cnt_is_zero) begin
            // Only reachable after a periodic reload of zero: terminal
            // without a borrow.
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = dec_cnt;
            bw_d  = dec_bw;
            if (cnt_is_one) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
`ifdef OCTAL_TIMER_PERIODIC_EN
        if (bus.periodic) begin
          cnt_d   = reload_q;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decoded from the registered state, plus registered data.
  always_comb begin
    bus.busy = (state_q == ST_RUN);
    bus.done = (state_q == ST_DONE);
    bus.cntr = cnt_q;
    bus.bw   = bw_q;
  end

endmodule
